md_unit: RTL and testbench

Iterative multiply/divide unit with the architectural HI/LO registers, instantiated inside the EX stage. It consumes the EX-stage `MDFunc`/`MDSign` controls and the forwarded rs/rt operands. It returns HI/LO to the EX result mux for MFHI/MFLO, and drives a `busy` flag that the stall detector uses to hold MULT/DIV/MTxx/MFxx in ID while an operation is in flight.

---
 rtl/md_unit.sv | 177 +++++++++++++++++
 tb/tb_md_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// MULT retires after MUL_CYCLES busy cycles; DIV runs 32 restoring steps.
module md_unit #(
    parameter int unsigned MUL_CYCLES = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        flush,
    input  logic [2:0]  md_func,
    input  logic        md_sign,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    localparam logic [2:0] FuncMult = 3'b001;
    localparam logic [2:0] FuncDiv  = 3'b010;
    localparam logic [2:0] FuncMthi = 3'b011;
    localparam logic [2:0] FuncMtlo = 3'b100;

    localparam logic [4:0] MulCnt = 5'(MUL_CYCLES - 1);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic        sign_q, sign_d;
    logic [31:0] rem_q, rem_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;

    logic        accept;
    logic        rs_neg, rt_neg;
    logic [31:0] rs_abs, rt_abs;
    logic [63:0] a_ext, b_ext, product;
    logic [32:0] rem_shift, diff;
    logic        take;
    logic [31:0] rem_next, quo_next, quo_fix, rem_fix;

    always_comb begin
        accept = start & ~flush & ~busy_q & (state_q == StIdle);

        rs_neg = md_sign & rs_val[31];
        rt_neg = md_sign & rt_val[31];
        rs_abs = rs_neg ? -rs_val : rs_val;
        rt_abs = rt_neg ? -rt_val : rt_val;

        a_ext   = {{32{sign_q & op_a_q[31]}}, op_a_q};
        b_ext   = {{32{sign_q & op_b_q[31]}}, op_b_q};
        product = a_ext * b_ext;

        // op_a_q doubles as the dividend/quotient shift register during DIV
        rem_shift = {rem_q, op_a_q[31]};
        diff      = rem_shift - {1'b0, op_b_q};
        take      = ~diff[32];
        rem_next  = take ? diff[31:0] : rem_shift[31:0];
        quo_next  = {op_a_q[30:0], take};
        quo_fix   = q_neg_q ? -quo_next : quo_next;
        rem_fix   = r_neg_q ? -rem_next : rem_next;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sign_d  = sign_q;
        rem_d   = rem_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (md_func)
                        FuncMult: begin
                            op_a_d  = rs_val;
                            op_b_d  = rt_val;
                            sign_d  = md_sign;
                            cnt_d   = MulCnt;
                            state_d = StMul;
                            busy_d  = 1'b1;
                        end
                        FuncDiv: begin
                            rem_d   = '0;
                            cnt_d   = 5'd31;
                            state_d = StDiv;
                            busy_d  = 1'b1;
                            if (rt_val == '0) begin
                                // Raw dividend with no fixup yields LO=all-ones, HI=rs
                                op_a_d  = rs_val;
                                op_b_d  = '0;
                                q_neg_d = 1'b0;
                                r_neg_d = 1'b0;
                            end else begin
                                op_a_d  = rs_abs;
                                op_b_d  = rt_abs;
                                q_neg_d = rs_neg ^ rt_neg;
                                r_neg_d = rs_neg;
                            end
                        end
                        FuncMthi: hi_d = rs_val;
                        FuncMtlo: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            StMul: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == '0) begin
                    hi_d    = product[63:32];
                    lo_d    = product[31:0];
                    cnt_d   = '0;
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            StDiv: begin
                op_a_d = quo_next;
                rem_d  = rem_next;
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == '0) begin
                    lo_d    = quo_fix;
                    hi_d    = rem_fix;
                    cnt_d   = '0;
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sign_q  <= 1'b0;
            rem_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sign_q  <= sign_d;
            rem_q   <= rem_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected {hi,lo} and busy length are queued at
// issue and compared once busy drops.
module tb_md_unit;

    localparam logic [2:0] FNone = 3'b000;
    localparam logic [2:0] FMult = 3'b001;
    localparam logic [2:0] FDiv  = 3'b010;
    localparam logic [2:0] FMthi = 3'b011;
    localparam logic [2:0] FMtlo = 3'b100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  md_func = FNone;
    logic        md_sign = 1'b0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        busy;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_q[$];
    int          lat_q[$];

    md_unit #(.MUL_CYCLES(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .flush   (flush),
        .md_func (md_func),
        .md_sign (md_sign),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; holds start across exactly one rising edge.
    task automatic drive(input logic [2:0] f, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic fl);
        md_func = f;
        md_sign = s;
        rs_val  = a;
        rt_val  = b;
        flush   = fl;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        flush   = 1'b0;
        md_func = FNone;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] f, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ae, be, q, r;
        ae = s ? {{32{a[31]}}, a} : {32'b0, a};
        be = s ? {{32{b[31]}}, b} : {32'b0, b};
        if (f == FMult) return ae * be;
        if (b == '0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            q = $signed(ae) / $signed(be);
            r = $signed(ae) % $signed(be);
        end else begin
            q = ae / be;
            r = ae % be;
        end
        return {r[31:0], q[31:0]};
    endfunction

    task automatic do_op(input string tag, input logic [2:0] f, input logic s,
                         input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        int n;
        logic [63:0] e;
        int l;
        exp_q.push_back(exp);
        lat_q.push_back((f == FMult) ? 5 : 32);
        drive(f, s, a, b, 1'b0);
        wait_idle(n);
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check({tag, "_lat"}, 64'(n), 64'(l));
        check({tag, "_hilo"}, {hi, lo}, e);
    endtask

    initial begin
        int n;
        logic [31:0] ra, rb;
        logic [2:0]  rf;
        logic        rsg;

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        repeat (3) @(negedge clk);
        check("idle_hold", {31'd0, busy, hi, lo}, 64'd0);

        do_op("mult_s", FMult, 1'b1, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
        do_op("multu", FMult, 1'b0, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA);
        do_op("div_s", FDiv, 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op("divu", FDiv, 1'b0, 32'd7, 32'd2, 64'h0000_0001_0000_0003);
        do_op("divu_by0", FDiv, 1'b0, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF);
        do_op("div_s_by0", FDiv, 1'b1, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF);
        do_op("div_ovf", FDiv, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);

        // Consecutive move-to writes, each visible one cycle later
        drive(FMthi, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b0);
        check("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
        check("mthi_busy", 64'(busy), 64'd0);
        drive(FMtlo, 1'b0, 32'h0BAD_F00D, 32'd0, 1'b0);
        check("mtlo_hilo", {hi, lo}, 64'hDEAD_BEEF_0BAD_F00D);
        check("mtlo_busy", 64'(busy), 64'd0);

        drive(FMult, 1'b1, 32'd5, 32'd5, 1'b1);
        check("flush_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("flush_hilo", {31'd0, busy, hi, lo}, {32'd0, 32'hDEAD_BEEF} << 32 | 64'h0BAD_F00D);

        // MTHI while a DIV is in flight must be ignored
        exp_q.push_back(64'h0000_0002_0000_000E);
        lat_q.push_back(32);
        drive(FDiv, 1'b0, 32'd100, 32'd7, 1'b0);
        repeat (2) @(negedge clk);
        drive(FMthi, 1'b0, 32'h1111_1111, 32'd0, 1'b0);
        check("mthi_busy_hi", 64'(hi), 64'hDEAD_BEEF);
        check("mthi_busy_flag", 64'(busy), 64'd1);
        wait_idle(n);
        check("div_mthi_lat", 64'(n + 3), 64'(lat_q.pop_front()));
        check("div_mthi_hilo", {hi, lo}, exp_q.pop_front());

        // Back-to-back: issued in the first non-busy cycle
        do_op("b2b_mult", FMult, 1'b0, 32'd6, 32'd7, 64'd42);
        do_op("b2b_div", FDiv, 1'b1, 32'd42, 32'hFFFF_FFFA, 64'h0000_0000_FFFF_FFF9);

        for (int i = 0; i < 8; i++) begin
            rf  = ($urandom_range(0, 1) == 0) ? FMult : FDiv;
            rsg = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = (i == 7) ? 32'd0 : $urandom >> $urandom_range(0, 28);
            do_op("rand", rf, rsg, ra, rb, model(rf, rsg, ra, rb));
        end

        // Reset asserted during the 10th busy cycle of a DIV
        drive(FDiv, 1'b0, 32'hFFFF_0000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        do_op("post_rst_mult", FMult, 1'b1, 32'd6, 32'd7, 64'd42);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
